// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter that advances once per rising edge of a divided tick level.
// Provides load with BCD clamping, wrap or saturate at the limits, and a terminal-count pulse.
module bcd_tick_counter #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_in,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  tc,
    output logic                  load_err
);

    logic                tick_d;
    logic                rise;
    logic                step;
    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] dec_val;
    logic [4*DIGITS-1:0] clamp_val;
    logic                carry;
    logic                borrow;
    logic                bad_digit;
    logic [3:0]          cur_digit;
    logic [3:0]          ld_digit;

    assign rise = tick_in & ~tick_d;
    assign step = rise & en & ~load;

    // Carry and borrow ripple through all digits in one cycle; the carry/borrow
    // left over past the top digit flags the all-9 / all-0 limit.
    always_comb begin
        inc_val   = '0;
        dec_val   = '0;
        clamp_val = '0;
        carry     = 1'b1;
        borrow    = 1'b1;
        bad_digit = 1'b0;
        cur_digit = '0;
        ld_digit  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            cur_digit = bcd[4*i +: 4];
            if (carry) begin
                if (cur_digit >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = cur_digit + 4'd1;
                    carry             = 1'b0;
                end
            end else begin
                inc_val[4*i +: 4] = cur_digit;
            end

            if (borrow) begin
                if (cur_digit == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = cur_digit - 4'd1;
                    borrow            = 1'b0;
                end
            end else begin
                dec_val[4*i +: 4] = cur_digit;
            end

            ld_digit = load_val[4*i +: 4];
            if (ld_digit > 4'd9) begin
                clamp_val[4*i +: 4] = 4'd9;
                bad_digit           = 1'b1;
            end else begin
                clamp_val[4*i +: 4] = ld_digit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd      <= '0;
            tc       <= 1'b0;
            load_err <= 1'b0;
            // Starts high so a tick level already present out of reset is not counted.
            tick_d   <= 1'b1;
        end else begin
            tick_d   <= tick_in;
            tc       <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                bcd      <= clamp_val;
                load_err <= bad_digit;
            end else if (step) begin
                if (up) begin
                    if (carry) begin
                        tc <= 1'b1;
                        if (WRAP) bcd <= inc_val;
                    end else begin
                        bcd <= inc_val;
                    end
                end else begin
                    if (borrow) begin
                        tc <= 1'b1;
                        if (WRAP) bcd <= dec_val;
                    end else begin
                        bcd <= dec_val;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Bench for bcd_tick_counter: a wrapping and a saturating instance share stimulus and
// are compared every cycle against an integer-valued reference model.
module tb_bcd_tick_counter;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MODV   = 10 ** DIGITS;
    localparam int MAXV   = MODV - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick_in = 1'b0;
    logic         en = 1'b1;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] bcd_w, bcd_s;
    logic         tc_w, tc_s, err_w, err_s;

    int errors = 0;
    int checks = 0;

    int m_w = 0;
    int m_s = 0;
    bit m_tick = 1'b1;
    bit e_tc_w, e_tc_s, e_err;

    always #5 clk = ~clk;

    bcd_tick_counter #(.DIGITS(DIGITS), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up(up),
        .load(load), .load_val(load_val), .bcd(bcd_w), .tc(tc_w), .load_err(err_w)
    );

    bcd_tick_counter #(.DIGITS(DIGITS), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up(up),
        .load(load), .load_val(load_val), .bcd(bcd_s), .tc(tc_s), .load_err(err_s)
    );

    function automatic logic [W-1:0] to_bcd(int v);
        logic [W-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int load_value(logic [W-1:0] lv);
        int v, p, d;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic bit has_bad(logic [W-1:0] lv);
        for (int i = 0; i < DIGITS; i++)
            if (lv[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: advance the model from the currently driven inputs, then check both DUTs.
    task automatic cycle();
        bit new_edge;
        new_edge = tick_in && !m_tick;
        e_tc_w = 1'b0;
        e_tc_s = 1'b0;
        e_err  = 1'b0;
        if (rst) begin
            m_w = 0;
            m_s = 0;
            m_tick = 1'b1;
        end else begin
            m_tick = tick_in;
            if (load) begin
                m_w = load_value(load_val);
                m_s = m_w;
                e_err = has_bad(load_val);
            end else if (new_edge && en) begin
                if (up) begin
                    if (m_w == MAXV) e_tc_w = 1'b1;
                    m_w = (m_w + 1) % MODV;
                    if (m_s == MAXV) e_tc_s = 1'b1;
                    else m_s = m_s + 1;
                end else begin
                    if (m_w == 0) e_tc_w = 1'b1;
                    m_w = (m_w + MODV - 1) % MODV;
                    if (m_s == 0) e_tc_s = 1'b1;
                    else m_s = m_s - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("bcd_wrap", 32'(bcd_w), 32'(to_bcd(m_w)));
        chk("bcd_sat",  32'(bcd_s), 32'(to_bcd(m_s)));
        chk("tc_wrap",  32'(tc_w),  32'(e_tc_w));
        chk("tc_sat",   32'(tc_s),  32'(e_tc_s));
        chk("err_wrap", 32'(err_w), 32'(e_err));
        chk("err_sat",  32'(err_s), 32'(e_err));
    endtask

    task automatic pulse(int hi, int lo);
        tick_in = 1'b1;
        for (int i = 0; i < hi; i++) cycle();
        tick_in = 1'b0;
        for (int i = 0; i < lo; i++) cycle();
    endtask

    task automatic do_load(logic [W-1:0] v);
        load = 1'b1;
        load_val = v;
        cycle();
        load = 1'b0;
    endtask

    initial begin
        int tc_count;
        #1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // Twelve multi-cycle pulses counting up
        for (int n = 0; n < 12; n++) pulse(3, 5);
        chk("count12", 32'(bcd_w), 32'h0012);

        // Upper limit
        do_load(16'h9998);
        up = 1'b1;
        tc_count = 0;
        tick_in = 1'b1;
        cycle();
        chk("upper_first", 32'(bcd_w), 32'h9999);
        tc_count += int'(tc_w);
        tick_in = 1'b0;
        cycle();
        tick_in = 1'b1;
        cycle();
        chk("upper_wrap", 32'(bcd_w), 32'h0000);
        chk("upper_sat",  32'(bcd_s), 32'h9999);
        tc_count += int'(tc_w);
        tick_in = 1'b0;
        cycle();
        tc_count += int'(tc_w);
        chk("upper_tc_once", 32'(tc_count), 32'd1);

        // Lower limit
        do_load(16'h0001);
        up = 1'b0;
        pulse(2, 2);
        chk("lower_first", 32'(bcd_s), 32'h0000);
        tick_in = 1'b1;
        cycle();
        chk("lower_sat_tc", 32'(tc_s), 32'd1);
        chk("lower_wrap",   32'(bcd_w), 32'h9999);
        tick_in = 1'b0;
        cycle();
        up = 1'b1;

        // Load coinciding with a tick rise
        tick_in = 1'b1;
        do_load(16'h0500);
        chk("load_vs_tick", 32'(bcd_w), 32'h0500);
        cycle();
        tick_in = 1'b0;
        cycle();
        pulse(1, 2);
        chk("after_load_tick", 32'(bcd_w), 32'h0501);

        // Non-BCD load clamps
        do_load(16'h0A3F);
        chk("clamp_val", 32'(bcd_w), 32'h0939);
        chk("clamp_err", 32'(err_w), 32'd1);
        cycle();

        // Reset while tick is high
        do_load(16'h0042);
        tick_in = 1'b1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        chk("rst_no_count", 32'(bcd_w), 32'h0000);
        tick_in = 1'b0;
        cycle();
        pulse(2, 2);
        chk("post_rst_rise", 32'(bcd_w), 32'h0001);
        en = 1'b0;
        pulse(2, 1);
        en = 1'b1;
        cycle();
        chk("en_low_lost", 32'(bcd_w), 32'h0001);

        // Randomised traffic, biased toward the limits via loads
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) tick_in = ~tick_in;
            en   = ($urandom_range(0, 9) != 0);
            up   = $urandom_range(0, 1) != 0;
            rst  = ($urandom_range(0, 149) == 0);
            load = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 3))
                0: load_val = 16'h9998;
                1: load_val = 16'h0001;
                default: load_val = W'($urandom);
            endcase
            cycle();
        end
        rst = 1'b0;
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
